mul_seq_ctrl: RTL and testbench

- Multi-cycle 32x32 multiplier sequencer for the ALU.
- Time-shares a single instance of the team's existing 32-bit ripple adder (fa_32bit: A, B, CIN -> SUM, COUT) for every arithmetic step:
  - two's-complement operand negation,
  - 32 shift-add iterations,
  - 64-bit product negation.
- Sits beside the ALU and is driven by the execute-stage control with a start/busy/done handshake.

---
 rtl/mul_pkg.sv | 20 ++
 rtl/fa_32bit.sv | 28 ++
 rtl/mul_seq_ctrl.sv | 164 ++++++++++++++++
 tb/tb_mul_seq_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared constants and state encoding for the sequential 32x32 multiplier.
// Both the controller and the adder it time-shares import this package.
package mul_pkg;

    localparam int unsigned WIDTH     = 32;
    localparam int unsigned CNT_W     = 6;
    localparam int unsigned ITER_LAST = WIDTH - 1;
    localparam int unsigned PROD_W    = 2 * WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_NEGA  = 3'd1,
        ST_NEGB  = 3'd2,
        ST_MUL   = 3'd3,
        ST_NEGLO = 3'd4,
        ST_NEGHI = 3'd5,
        ST_DONE  = 3'd6
    } state_e;

endpackage

// File: rtl/fa_32bit.sv
// 32-bit ripple-carry adder. It is shared by every arithmetic step of the
// multiplier sequencer.
module fa_32bit
    import mul_pkg::*;
(
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT
);

    logic [WIDTH:0] carry;

    // Bit-serial carry chain, one full adder per bit.
    always_comb begin
        carry    = '0;
        SUM      = '0;
        carry[0] = CIN;
        for (int i = 0; i < int'(WIDTH); i++) begin
            SUM[i]     = A[i] ^ B[i] ^ carry[i];
            carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
        end
    end

    assign COUT = carry[WIDTH];

endmodule

// File: rtl/mul_seq_ctrl.sv
// Multi-cycle signed/unsigned 32x32 shift-add multiplier.
// All negations and iterations go through one shared fa_32bit instance.
module mul_seq_ctrl
    import mul_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              is_signed,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic              busy,
    output logic              done,
    output logic [PROD_W-1:0] product
);

    state_e             state_q, state_d, first_state_c;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic               carry_sv_q, carry_sv_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [PROD_W-1:0]  product_q, product_d;

    logic [WIDTH-1:0]   add_a_c, add_b_c, add_sum_c;
    logic               add_cin_c, add_cout_c;
    logic               accept_c;

    fa_32bit u_adder (
        .A    (add_a_c),
        .B    (add_b_c),
        .CIN  (add_cin_c),
        .SUM  (add_sum_c),
        .COUT (add_cout_c)
    );

    assign accept_c = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        first_state_c = ST_MUL;
        if (is_signed && a[WIDTH-1]) begin
            first_state_c = ST_NEGA;
        end else if (is_signed && b[WIDTH-1]) begin
            first_state_c = ST_NEGB;
        end

        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = first_state_c;
            ST_DONE:  state_d = start ? first_state_c : ST_IDLE;
            // In NEGA the multiplicand was negative, so b was negative exactly when neg is clear.
            ST_NEGA:  state_d = neg_q ? ST_MUL : ST_NEGB;
            ST_NEGB:  state_d = ST_MUL;
            ST_MUL: begin
                if (cnt_q == CNT_W'(ITER_LAST)) begin
                    state_d = neg_q ? ST_NEGLO : ST_DONE;
                end
            end
            ST_NEGLO: state_d = ST_NEGHI;
            ST_NEGHI: state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Adder operand muxing and datapath next-state per FSM state.
    always_comb begin
        add_a_c    = '0;
        add_b_c    = '0;
        add_cin_c  = 1'b0;
        mcand_d    = mcand_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        cnt_d      = cnt_q;
        neg_d      = neg_q;
        carry_sv_d = carry_sv_q;

        if (accept_c) begin
            mcand_d = a;
            lo_d    = b;
            hi_d    = '0;
            cnt_d   = '0;
            neg_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        end else begin
            unique case (state_q)
                ST_NEGA: begin
                    add_a_c   = ~mcand_q;
                    add_cin_c = 1'b1;
                    mcand_d   = add_sum_c;
                end
                ST_NEGB: begin
                    add_a_c   = ~lo_q;
                    add_cin_c = 1'b1;
                    lo_d      = add_sum_c;
                end
                ST_MUL: begin
                    add_a_c = hi_q;
                    add_b_c = lo_q[0] ? mcand_q : '0;
                    hi_d    = {add_cout_c, add_sum_c[WIDTH-1:1]};
                    lo_d    = {add_sum_c[0], lo_q[WIDTH-1:1]};
                    cnt_d   = cnt_q + CNT_W'(1);
                end
                ST_NEGLO: begin
                    add_a_c    = ~lo_q;
                    add_cin_c  = 1'b1;
                    lo_d       = add_sum_c;
                    carry_sv_d = add_cout_c;
                end
                ST_NEGHI: begin
                    add_a_c   = ~hi_q;
                    add_cin_c = carry_sv_q;
                    hi_d      = add_sum_c;
                end
                default: ;
            endcase
        end

        busy_d    = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d    = (state_d == ST_DONE);
        product_d = product_q;
        if (state_d == ST_DONE) begin
            product_d = {hi_d, lo_d};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q    <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            carry_sv_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            product_q  <= '0;
        end else begin
            mcand_q    <= mcand_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            cnt_q      <= cnt_d;
            neg_q      <= neg_d;
            carry_sv_q <= carry_sv_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            product_q  <= product_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl: a table of operand/product/latency vectors
// plus hand-written sequences for ignored start, async reset and back-to-back.
module tb_mul_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] product;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] prod;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    mul_seq_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .product   (product)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Wait for done, counting edges from the accept edge and busy-high samples.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 1;
        busy_cnt = 0;
        while (!done && lat < 60) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input string name, input logic sg, input logic [31:0] va,
                          input logic [31:0] vb, input logic [63:0] exp_p, input int exp_lat);
        int lat;
        int bc;
        is_signed = sg;
        a         = va;
        b         = vb;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, bc);
        chk({name, "_done_seen"}, 64'(done), 64'd1);
        chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({name, "_product"}, product, exp_p);
        chk({name, "_busy_cycles"}, 64'(bc), 64'(exp_lat - 1));
        @(posedge clk); #1;
        chk({name, "_done_pulse"}, 64'({done, busy}), 64'd0);
        chk({name, "_product_hold"}, product, exp_p);
    endtask

    initial begin
        int lat;
        int bc;

        vecs[0] = '{1'b0, 32'h0000000B, 32'h0000000A, 64'h000000000000006E, 33};
        vecs[1] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 33};
        vecs[2] = '{1'b1, 32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFFFFFFFFEB, 36};
        vecs[3] = '{1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000, 35};
        vecs[4] = '{1'b1, 32'h80000000, 32'h00000001, 64'hFFFFFFFF80000000, 36};
        vecs[5] = '{1'b0, 32'h80000000, 32'h00000002, 64'h0000000100000000, 33};
        vecs[6] = '{1'b1, 32'h00000005, 32'hFFFFFFFA, 64'hFFFFFFFFFFFFFFE2, 36};
        vecs[7] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001, 35};

        reset     = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        a         = '0;
        b         = '0;
        @(posedge clk); @(posedge clk); #1;
        chk("reset_outputs", {62'd0, busy, done}, 64'd0);
        chk("reset_product", product, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].sg, vecs[i].a, vecs[i].b,
                   vecs[i].prod, vecs[i].lat);
        end

        // start pulsed mid-MUL with different operands must be ignored
        is_signed = 1'b0;
        a         = 32'h00001234;
        b         = 32'h00000010;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        is_signed = 1'b1;
        a         = 32'hFFFF0000;
        b         = 32'h8000FFFF;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ignored_start_busy", 64'(busy), 64'd1);
        wait_done(lat, bc);
        chk("ignored_start_latency", 64'(lat + 11), 64'd33);
        chk("ignored_start_product", product, 64'h0000000000012340);
        @(posedge clk); #1;

        // async reset mid-MUL clears outputs without waiting for an edge
        is_signed = 1'b0;
        a         = 32'h00000009;
        b         = 32'h00000009;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        #2 reset = 1'b1;
        #1;
        chk("async_reset_flags", {62'd0, busy, done}, 64'd0);
        chk("async_reset_product", product, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        run_op("after_reset", 1'b0, 32'd5, 32'd6, 64'h000000000000001E, 33);

        // back-to-back: start held high; second operands accepted in the DONE cycle
        is_signed = 1'b0;
        a         = 32'd7;
        b         = 32'd9;
        start     = 1'b1;
        @(posedge clk); #1;
        a = 32'd2;
        b = 32'd3;
        wait_done(lat, bc);
        chk("b2b_first_latency", 64'(lat), 64'd33);
        chk("b2b_first_product", product, 64'd63);
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_no_idle", 64'({busy, done}), 64'b10);
        wait_done(lat, bc);
        chk("b2b_second_latency", 64'(lat), 64'd33);
        chk("b2b_second_product", product, 64'd6);
        @(posedge clk); #1;
        chk("b2b_idle", 64'({busy, done}), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
